// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, default
// widths and the helpers that derive field widths from the parameters.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DATA_SIZE_DEF = 10;
  localparam int MAX_BURST_DEF = 4;

  // Width needed to hold a burst length in 0..max_burst.
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Width of a requester index, never less than one bit.
  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: finds the first asserted request strictly after
// last_idx, wrapping modulo NUM_REQ. Purely combinational.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               valid
);

  // Wrap-around search; the first hit after last_idx wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!valid && req[(int'(last_idx) + off) % NUM_REQ]) begin
        valid = 1'b1;
        pick[(int'(last_idx) + off) % NUM_REQ] = 1'b1;
        pick_idx = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX FIFO write port between NUM_REQ requesters. Grants are
// round-robin, one burst at a time, held until the burst completes or the
// granted requester drops its request.
//
// Handshake: a word moves when s_tick & fifo_wr is high in a cycle; fifo_wr
// is req[g] & ~fifo_full, so it never rises while the FIFO is full, and
// req_ack[g] pulses in exactly the cycles a word is accepted. Requesters
// keep req_data stable until they see req_ack.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int LEN_W     = len_w(MAX_BURST),
  parameter int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  input  logic                         fifo_full,
  output logic                         fifo_wr,
  output logic [DATA_SIZE-1:0]         fifo_w_data,
  output logic                         busy,
  output logic                         abort,
  output logic                         dbg_state
);

  state_t             state;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   g_idx;
  logic [LEN_W-1:0]   remaining;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [LEN_W-1:0]   pick_len;
  logic [LEN_W-1:0]   load_len;
  logic               g_req;
  logic               accept;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // Clamp the winner's length: 0 means a single word, oversize saturates.
  always_comb begin
    pick_len = req_len[int'(pick_idx)*LEN_W +: LEN_W];
    if (pick_len == '0) begin
      load_len = LEN_W'(1);
    end else if (pick_len > LEN_W'(MAX_BURST)) begin
      load_len = LEN_W'(MAX_BURST);
    end else begin
      load_len = pick_len;
    end
  end

  // Write port: data mux on the registered grant, full gated locally.
  always_comb begin
    g_req       = (state == ST_XFER) && req[g_idx];
    fifo_wr     = g_req && !fifo_full;
    accept      = s_tick && fifo_wr;
    req_ack     = accept ? grant : '0;
    fifo_w_data = (state == ST_XFER) ? req_data[int'(g_idx)*DATA_SIZE +: DATA_SIZE] : '0;
  end

  assign busy      = (state == ST_XFER);
  assign dbg_state = state;

  // Arbitration FSM: IDLE picks a winner, XFER counts accepted words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      g_idx     <= '0;
      remaining <= '0;
      last_idx  <= IDX_W'(NUM_REQ - 1);
      abort     <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            g_idx     <= pick_idx;
            remaining <= load_len;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!req[g_idx]) begin
            // Requester gave up mid-burst: release the port without a write.
            abort     <= 1'b1;
            grant     <= '0;
            remaining <= '0;
            last_idx  <= g_idx;
            state     <= ST_IDLE;
          end else if (accept) begin
            if (remaining == LEN_W'(1)) begin
              grant     <= '0;
              remaining <= '0;
              last_idx  <= g_idx;
              state     <= ST_IDLE;
            end else begin
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
